// File: rtl/int_sync_crossing_sink_n.sv
// Interrupt sink for an asynchronous crossing: per-channel synchronizer followed by
// either a level passthrough or a sticky edge latch with overflow detection.
module int_sync_crossing_sink_n #(
  parameter int                NUM_CH      = 1,
  parameter int                SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] EDGE_MASK   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] auto_in_sync,
  input  logic [NUM_CH-1:0] clear,
  output logic [NUM_CH-1:0] auto_out,
  output logic [NUM_CH-1:0] overflow,
  output logic              auto_out_any
);

  logic [NUM_CH-1:0] s_p0;
  logic [NUM_CH-1:0] prev_p1;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] pending_p1;
  logic [NUM_CH-1:0] overflow_p1;
  logic [NUM_CH-1:0] pending_d;
  logic [NUM_CH-1:0] overflow_d;

  // Synchronizer stage: s_p0 is the chain output, or the raw line with no chain.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_p0 = auto_in_sync;
    end else begin : g_sync
      logic [NUM_CH-1:0] sync_p [SYNC_STAGES];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_p[k] <= '0;
        end else begin
          sync_p[0] <= auto_in_sync;
          for (int k = 1; k < SYNC_STAGES; k++) sync_p[k] <= sync_p[k-1];
        end
      end

      assign s_p0 = sync_p[SYNC_STAGES-1];
    end
  endgenerate

  // A rise landing in the same cycle as clear re-arms pending, so no edge is lost.
  always_comb begin
    rise       = s_p0 & ~prev_p1;
    pending_d  = EDGE_MASK & (rise | (pending_p1 & ~clear));
    overflow_d = EDGE_MASK & ~clear & (overflow_p1 | (rise & pending_p1));
    auto_out   = (EDGE_MASK & pending_p1) | (~EDGE_MASK & s_p0);
    overflow   = overflow_p1;
  end

  // Edge-detect / latch stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_p1      <= '0;
      pending_p1   <= '0;
      overflow_p1  <= '0;
      auto_out_any <= 1'b0;
    end else begin
      prev_p1      <= s_p0;
      pending_p1   <= pending_d;
      overflow_p1  <= overflow_d;
      auto_out_any <= |auto_out;
    end
  end

endmodule

// File: tb/tb_int_sync_crossing_sink_n.sv
// Bench for int_sync_crossing_sink_n: 4-channel mixed level/edge instance driven from a
// vector table, reset corner sequence, and a 1-channel legacy passthrough instance.
module tb_int_sync_crossing_sink_n;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [3:0] in_v, clr_v;
  logic [3:0] out_v, ovf_v;
  logic       any_v;
  logic       l_in, l_clr;
  logic       l_out, l_ovf, l_any;

  int_sync_crossing_sink_n #(.NUM_CH(4), .SYNC_STAGES(2), .EDGE_MASK(4'b1100)) dut (
    .clock(clock), .reset(reset), .auto_in_sync(in_v), .clear(clr_v),
    .auto_out(out_v), .overflow(ovf_v), .auto_out_any(any_v)
  );

  int_sync_crossing_sink_n #(.NUM_CH(1), .SYNC_STAGES(0), .EDGE_MASK(1'b0)) dut_legacy (
    .clock(clock), .reset(reset), .auto_in_sync(l_in), .clear(l_clr),
    .auto_out(l_out), .overflow(l_ovf), .auto_out_any(l_any)
  );

  typedef struct packed {
    logic [3:0] in;
    logic [3:0] clr;
    logic [3:0] out;
    logic [3:0] ovf;
    logic       any;
  } vec_t;

  localparam int NVEC = 34;
  vec_t vecs [NVEC];
  vec_t exp_q [$];
  vec_t e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  initial begin
    // {in, clr, expected auto_out, expected overflow, expected auto_out_any} after one edge
    vecs[0]  = {4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[1]  = {4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    vecs[2]  = {4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1};
    vecs[3]  = {4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    vecs[4]  = {4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[5]  = {4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[6]  = {4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[7]  = {4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b0};
    vecs[8]  = {4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b1};
    vecs[9]  = {4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b1};
    vecs[10] = {4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b1};
    vecs[11] = {4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b1};
    vecs[12] = {4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b1};
    vecs[13] = {4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b1};
    vecs[14] = {4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b1};
    vecs[15] = {4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[16] = {4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[17] = {4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[18] = {4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b0};
    vecs[19] = {4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b1};
    vecs[20] = {4'b0010, 4'b0011, 4'b1000, 4'b0000, 1'b1};
    vecs[21] = {4'b0010, 4'b0010, 4'b1010, 4'b0000, 1'b1};
    vecs[22] = {4'b0000, 4'b0000, 4'b1010, 4'b0000, 1'b1};
    vecs[23] = {4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b1};
    vecs[24] = {4'b0000, 4'b1000, 4'b0000, 4'b0000, 1'b1};
    vecs[25] = {4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[26] = {4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[27] = {4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[28] = {4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b0};
    vecs[29] = {4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b1};
    vecs[30] = {4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1};
    vecs[31] = {4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[32] = {4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[33] = {4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};

    reset = 1'b1;
    in_v  = '0;
    clr_v = '0;
    l_in  = 1'b0;
    l_clr = 1'b0;
    #1;
    chk("reset_out", out_v, 4'b0000);
    chk("reset_ovf", ovf_v, 4'b0000);
    chk("reset_any", {3'b0, any_v}, 4'b0000);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      in_v  = vecs[i].in;
      clr_v = vecs[i].clr;
      exp_q.push_back(vecs[i]);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_out", i), out_v, e.out);
      chk($sformatf("vec%0d_ovf", i), ovf_v, e.ovf);
      chk($sformatf("vec%0d_any", i), {3'b0, any_v}, {3'b0, e.any});
    end

    // Latch ch3, then hit it with a mid-cycle asynchronous reset.
    in_v  = 4'b1000;
    clr_v = 4'b0000;
    repeat (4) @(posedge clock);
    #1;
    chk("pre_rst_out", out_v, 4'b1000);
    chk("pre_rst_any", {3'b0, any_v}, 4'b0001);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out", out_v, 4'b0000);
    chk("async_rst_ovf", ovf_v, 4'b0000);
    chk("async_rst_any", {3'b0, any_v}, 4'b0000);
    #2 reset = 1'b0;
    @(posedge clock); #1;
    chk("rel_edge1_out", out_v, 4'b0000);
    @(posedge clock); #1;
    chk("rel_edge2_out", out_v, 4'b0000);
    @(posedge clock); #1;
    chk("rel_edge3_out", out_v, 4'b1000);
    in_v = 4'b0000;

    // Legacy instance: pure combinational passthrough, registered OR one cycle later.
    for (int c = 0; c < 1000; c++) begin
      logic prev_in;
      prev_in = l_in;
      @(posedge clock);
      #1;
      chk("legacy_any", {3'b0, l_any}, {3'b0, prev_in});
      l_in  = 1'($urandom_range(0, 1));
      l_clr = 1'($urandom_range(0, 1));
      #1;
      chk("legacy_out", {3'b0, l_out}, {3'b0, l_in});
      if (c % 100 == 0) chk("legacy_ovf", {3'b0, l_ovf}, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
